// File: rtl/seq_detect_prog_if.sv
// seq_detect_prog_if: config, serial input and match status bundle
// for the programmable bit-pattern detector.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               en;
  logic               in_valid;
  logic               in_bit;
  logic               clr_cnt;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output en, in_valid, in_bit, clr_cnt,
    input  match, match_cnt, cfg_err
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  en, in_valid, in_bit, clr_cnt,
    output match, match_cnt, cfg_err
  );
endinterface

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial pattern detector
// with overlap select, registered match pulse and saturating count.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0010_1101,
  parameter logic [LEN_W-1:0]   DEF_LEN     = 4'd6,
  parameter logic               DEF_OVERLAP = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  seq_detect_prog_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_HUNT
  } state_t;

  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  state_t             state_nx;
  logic [MAX_LEN-2:0] hist;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_inc;
  logic               ovl;
  logic               match_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt;

  logic acc;
  logic cfg_ok;
  logic cfg_apply;
  logic full_now;
  logic hit;
  logic match_ev;
  logic clr_hist;

  // A config strobe steals the cycle: the bit offered alongside is dropped.
  assign acc       = bus.en && bus.in_valid && !bus.cfg_load;
  assign cfg_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_L);
  assign cfg_apply = bus.cfg_load && cfg_ok;

  // Candidate window = stored history plus the bit arriving now.
  assign cand     = {hist, bus.in_bit};
  assign mask     = ~({MAX_LEN{1'b1}} << len);
  assign hit      = ((cand ^ pat) & mask) == '0;
  assign fill_inc = (fill >= len) ? len : fill + 1'b1;
  assign full_now = acc && (fill_inc == len);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode, highest priority first.
  always_comb begin
    state_nx = state;
    priority case (1'b1)
      !bus.en:              state_nx = S_IDLE;
      cfg_apply:            state_nx = S_FILL;
      match_ev && !ovl:     state_nx = S_FILL;
      full_now:             state_nx = S_HUNT;
      state == S_IDLE:      state_nx = S_FILL;
      default:              state_nx = state;
    endcase
  end

  // Match event and history-clear decode per state.
  always_comb begin
    match_ev = 1'b0;
    clr_hist = 1'b0;
    unique case (state)
      S_IDLE:  match_ev = full_now && hit;
      S_FILL:  match_ev = full_now && hit;
      S_HUNT:  match_ev = acc && hit;
      default: match_ev = 1'b0;
    endcase
    if (!bus.en || cfg_apply || (match_ev && !ovl))
      clr_hist = 1'b1;
  end

  // History shift register and fill counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr_hist) begin
      hist <= '0;
      fill <= '0;
    end else if (acc) begin
      hist <= cand[MAX_LEN-2:0];
      fill <= fill_inc;
    end
  end

  // Active configuration and sticky error on a rejected load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat   <= DEF_PATTERN;
      len   <= DEF_LEN;
      ovl   <= DEF_OVERLAP;
      err_q <= 1'b0;
    end else if (cfg_apply) begin
      pat   <= bus.cfg_pattern;
      len   <= bus.cfg_len;
      ovl   <= bus.cfg_overlap;
    end else if (bus.cfg_load) begin
      err_q <= 1'b1;
    end
  end

  // Registered match pulse and saturating match counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      cnt     <= '0;
    end else begin
      match_q <= match_ev;
      if (bus.clr_cnt)
        cnt <= match_ev ? CNT_W'(1) : '0;
      else if (match_ev && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt;
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed and random checks of seq_detect_prog
// against a queue-based reference of the detection rules.
module tb_seq_detect_prog;

  localparam int ML = 8;
  localparam int LW = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_detect_prog_if #(.MAX_LEN(ML), .LEN_W(LW), .CNT_W(CW)) bus ();

  seq_detect_prog #(
    .MAX_LEN(ML), .LEN_W(LW), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  bit          q[$];
  bit [ML-1:0] m_pat;
  int          m_len;
  bit          m_ovl;
  int          m_cnt;
  bit          m_err;
  bit          m_match;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step();
    bit ev;
    ev = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_pat = 8'b0010_1101;
      m_len = 6;
      m_ovl = 1'b1;
      m_cnt = 0;
      m_err = 1'b0;
      m_match = 1'b0;
      return;
    end
    if (bus.cfg_load) begin
      if (bus.cfg_len >= 1 && int'(bus.cfg_len) <= ML) begin
        m_pat = bus.cfg_pattern;
        m_len = int'(bus.cfg_len);
        m_ovl = bus.cfg_overlap;
        q.delete();
      end else begin
        m_err = 1'b1;
      end
    end else if (bus.en && bus.in_valid) begin
      q.push_back(bus.in_bit);
      if (q.size() > ML) void'(q.pop_front());
      if (q.size() >= m_len) begin
        ev = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (q[q.size() - m_len + i] != m_pat[m_len - 1 - i]) ev = 1'b0;
      end
      if (ev && !m_ovl) q.delete();
    end
    if (!bus.en) q.delete();
    if (bus.clr_cnt) m_cnt = ev ? 1 : 0;
    else if (ev && m_cnt < CMAX) m_cnt++;
    m_match = ev;
  endfunction

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, "_match"}, 32'(bus.match), 32'(m_match));
    chk({tag, "_cnt"}, 32'(bus.match_cnt), 32'(m_cnt));
    chk({tag, "_err"}, 32'(bus.cfg_err), 32'(m_err));
  endtask

  task automatic bit_in(input bit b, input string tag);
    bus.in_valid = 1'b1;
    bus.in_bit = b;
    cyc(tag);
    bus.in_valid = 1'b0;
  endtask

  task automatic bubble(input string tag);
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b1;
    cyc(tag);
  endtask

  task automatic load(input bit [ML-1:0] p, input bit [LW-1:0] l,
                      input bit o, input string tag);
    bus.cfg_load = 1'b1;
    bus.cfg_pattern = p;
    bus.cfg_len = l;
    bus.cfg_overlap = o;
    bus.in_valid = 1'b1;
    bus.in_bit = p[0];
    cyc(tag);
    bus.cfg_load = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input bit [15:0] bits, input int n,
                      input string tag, output int pm);
    pm = 0;
    for (int i = 0; i < n; i++) begin
      bit_in(bits[n - 1 - i], tag);
      if (bus.match === 1'b1) pm |= (1 << i);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc("rst");
    rst_n = 1'b1;
  endtask

  int pm;

  initial begin
    bus.cfg_load = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len = '0;
    bus.cfg_overlap = 1'b0;
    bus.en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    bus.clr_cnt = 1'b0;

    // T1: defaults, overlapping
    do_reset();
    chk("rst_match", 32'(bus.match), 0);
    chk("rst_cnt", 32'(bus.match_cnt), 0);
    chk("rst_err", 32'(bus.cfg_err), 0);
    bus.en = 1'b1;
    send(16'b10_1101_1011, 10, "t1", pm);
    chk("t1_pulses", 32'(pm), 32'h120);
    chk("t1_cnt", 32'(bus.match_cnt), 2);

    // T2: same bits, non-overlapping
    do_reset();
    bus.en = 1'b1;
    load(8'b0010_1101, 4'd6, 1'b0, "t2_ld");
    send(16'b10_1101_1011, 10, "t2", pm);
    chk("t2_pulses", 32'(pm), 32'h020);
    chk("t2_cnt", 32'(bus.match_cnt), 1);

    // T3: 3-bit pattern with bubbles between bits
    do_reset();
    bus.en = 1'b1;
    load(8'b0000_0110, 4'd3, 1'b1, "t3_ld");
    pm = 0;
    for (int i = 0; i < 6; i++) begin
      bit [5:0] s;
      s = 6'b110110;
      bit_in(s[5 - i], "t3");
      if (bus.match === 1'b1) pm |= (1 << i);
      bubble("t3_bub");
      bubble("t3_bub");
    end
    chk("t3_pulses", 32'(pm), 32'h24);
    chk("t3_cnt", 32'(bus.match_cnt), 2);

    // T4: rejected loads keep the old pattern
    do_reset();
    bus.en = 1'b1;
    load(8'b0000_0011, 4'd0, 1'b1, "t4_ld0");
    chk("t4_err0", 32'(bus.cfg_err), 1);
    load(8'b0000_0011, 4'd9, 1'b1, "t4_ld9");
    chk("t4_err9", 32'(bus.cfg_err), 1);
    send(16'b10_1101, 6, "t4", pm);
    chk("t4_pulses", 32'(pm), 32'h20);

    // T5: counter saturation and clear-with-match
    do_reset();
    bus.en = 1'b1;
    load(8'b0000_0001, 4'd1, 1'b0, "t5_ld");
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b1, "t5");
      chk("t5_sat", 32'(bus.match_cnt), (i < 3) ? i + 1 : 3);
    end
    bus.clr_cnt = 1'b1;
    bit_in(1'b1, "t5_clr");
    bus.clr_cnt = 1'b0;
    chk("t5_clr_cnt", 32'(bus.match_cnt), 1);
    bus.clr_cnt = 1'b1;
    bubble("t5_clr0");
    bus.clr_cnt = 1'b0;
    chk("t5_clr0_cnt", 32'(bus.match_cnt), 0);

    // T6: enable drop loses partial history; reset mid-stream
    do_reset();
    bus.en = 1'b1;
    send(16'b1_0110, 5, "t6a", pm);
    bus.en = 1'b0;
    bubble("t6_off");
    bus.en = 1'b1;
    bit_in(1'b1, "t6_re");
    chk("t6_re_match", 32'(bus.match), 0);
    send(16'b10_1101, 6, "t6b", pm);
    chk("t6_pulses", 32'(pm), 32'h20);
    load(8'h00, 4'd0, 1'b0, "t6_bad");
    send(16'b101, 3, "t6c", pm);
    do_reset();
    chk("t6_rst_match", 32'(bus.match), 0);
    chk("t6_rst_cnt", 32'(bus.match_cnt), 0);
    chk("t6_rst_err", 32'(bus.cfg_err), 0);

    // Random traffic against the reference
    bus.en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      rst_n = (r == 0) ? 1'b0 : 1'b1;
      bus.cfg_load = (r >= 1 && r <= 4);
      bus.cfg_pattern = ML'($urandom);
      if ($urandom_range(0, 9) < 7)
        bus.cfg_len = LW'($urandom_range(1, 4));
      else
        bus.cfg_len = LW'($urandom_range(0, 15));
      bus.cfg_overlap = 1'($urandom);
      bus.en = ($urandom_range(0, 19) != 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_bit = 1'($urandom);
      bus.clr_cnt = ($urandom_range(0, 29) == 0);
      cyc("rnd");
    end
    rst_n = 1'b1;
    bus.cfg_load = 1'b0;
    bus.clr_cnt = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
